// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, keyboard command bytes, frame size.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    DATA      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // start + 8 data + parity + stop
  localparam int unsigned PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock/data lines plus a clock falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_s,
  output logic o_dat_s,
  output logic o_fall_c
);

  logic r_clk_meta, r_clk_s, r_clk_prev;
  logic r_dat_meta, r_dat_s;

  // Lines idle high, so the flops reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_meta <= 1'b1;
      r_clk_s    <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_s    <= 1'b1;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_s    <= r_clk_meta;
      r_clk_prev <= r_clk_s;
      r_dat_meta <= i_ps2_dat;
      r_dat_s    <= r_dat_meta;
    end
  end

  assign o_clk_s  = r_clk_s;
  assign o_dat_s  = r_dat_s;
  assign o_fall_c = r_clk_prev & ~r_clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain line enables).
// Define PS2_TX_RESEND_EN to retry a failed frame once before reporting error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CLK = 5000,
  parameter int unsigned TIMEOUT_CLK = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_W  = $clog2(INHIBIT_CLK + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CLK + 1);
  localparam int unsigned EDGE_W = $clog2(PS2_FRAME_BITS + 1);

  ps2_state_e        r_state, w_state_nxt;
  logic [9:0]        r_frame, w_frame_nxt;
  logic [INH_W-1:0]  r_inh_cnt, w_inh_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic [EDGE_W-1:0] r_edge_cnt, w_edge_cnt_nxt;
  logic r_busy, r_done, r_error, r_clk_oe, r_dat_oe;
  logic w_busy_nxt, w_done_nxt, w_error_nxt, w_clk_oe_nxt, w_dat_oe_nxt;
  logic w_clk_s, w_dat_s, w_fall;
  logic w_inh_done, w_timeout, w_ack_ok, w_nack, w_idle_ok, w_fail, w_retry_ok;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ps2_clk (ps2_clk_in),
    .i_ps2_dat (ps2_dat_in),
    .o_clk_s   (w_clk_s),
    .o_dat_s   (w_dat_s),
    .o_fall_c  (w_fall)
  );

  assign w_inh_done = (r_inh_cnt == INH_W'(INHIBIT_CLK - 1));
  assign w_timeout  = (r_state inside {DATA, ACK, WAIT_IDLE}) &&
                      (r_to_cnt == TO_W'(TIMEOUT_CLK - 1));
  assign w_ack_ok   = (r_state == ACK) && w_fall && !w_dat_s;
  assign w_nack     = (r_state == ACK) && w_fall && w_dat_s;
  assign w_idle_ok  = (r_state == WAIT_IDLE) && w_clk_s && w_dat_s;
  assign w_fail     = w_timeout || w_nack;

`ifdef PS2_TX_RESEND_EN
  logic r_retry, w_retry_nxt;

  assign w_retry_ok = ~r_retry;

  always_comb begin
    w_retry_nxt = r_retry;
    if (r_state == IDLE && send) w_retry_nxt = 1'b0;
    else if (w_fail)             w_retry_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_retry <= 1'b0;
    else        r_retry <= w_retry_nxt;
  end
`else
  assign w_retry_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (send) w_state_nxt = INHIBIT;
      INHIBIT:   if (w_inh_done) w_state_nxt = RTS;
      RTS:       w_state_nxt = DATA;
      DATA:      if (w_fall && r_edge_cnt == EDGE_W'(PS2_FRAME_BITS - 2)) w_state_nxt = ACK;
      ACK:       if (w_ack_ok) w_state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (w_idle_ok) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    // A failure overrides any same-cycle progress.
    if (w_fail) w_state_nxt = w_retry_ok ? INHIBIT : IDLE;
  end

  always_comb begin
    w_frame_nxt    = r_frame;
    w_busy_nxt     = (w_state_nxt != IDLE);
    w_done_nxt     = w_idle_ok && !w_timeout;
    w_error_nxt    = w_fail && !w_retry_ok;
    w_clk_oe_nxt   = (w_state_nxt == INHIBIT);
    w_dat_oe_nxt   = 1'b0;
    w_edge_cnt_nxt = r_edge_cnt;
    w_inh_cnt_nxt  = (r_state == INHIBIT && w_state_nxt == INHIBIT) ?
                     r_inh_cnt + INH_W'(1) : '0;
    w_to_cnt_nxt   = (r_state inside {DATA, ACK, WAIT_IDLE}) ? r_to_cnt + TO_W'(1) : '0;

    if (r_state == IDLE && send) w_frame_nxt = {1'b1, ~^data, data};

    if (r_state == RTS)              w_edge_cnt_nxt = '0;
    else if (r_state == DATA && w_fall) w_edge_cnt_nxt = r_edge_cnt + EDGE_W'(1);

    // Start bit is driven in RTS; each fall in DATA moves to the next frame bit (stop = release).
    if (w_state_nxt == RTS) begin
      w_dat_oe_nxt = 1'b1;
    end else if (r_state == DATA && (w_state_nxt inside {DATA, ACK})) begin
      w_dat_oe_nxt = w_fall ? ~r_frame[r_edge_cnt] : r_dat_oe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame    <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_edge_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
    end else begin
      r_frame    <= w_frame_nxt;
      r_inh_cnt  <= w_inh_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_dat_oe   <= w_dat_oe_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a device model clocks frames; a monitor checks done/error results.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 5000;
  localparam int unsigned TO  = 2000;
  localparam int unsigned H   = 40;   // device half clock period in system cycles
`ifdef PS2_TX_RESEND_EN
  localparam int TRIES = 2;
`else
  localparam int TRIES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       send = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       busy, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;

  // Open-drain wired-AND of host and device drivers
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CLK(INH), .TIMEOUT_CLK(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .send       (send),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    bit         chk_frame;
    bit         chk_to;
    logic [9:0] frame;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rts_cyc = 0;
  int         inh_run = 0;
  logic [9:0] cap_frame = '0;
  logic       prev_done = 1'b0, prev_error = 1'b0, prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Monitor: inhibit width, RTS timestamp, and scoreboard pop on every done/error pulse.
  always @(negedge clk) begin
    cyc++;
    if (ps2_dat_oe && !prev_dat_oe && !ps2_clk_oe && prev_clk_oe) rts_cyc = cyc;
    if (ps2_clk_oe === 1'b1) inh_run++;
    else begin
      if (prev_clk_oe === 1'b1) check("inhibit_len", inh_run, INH);
      inh_run = 0;
    end
    if (done === 1'b1 || error === 1'b1) begin
      check("done_error_exclusive", {31'd0, done & error}, 0);
      check("pulse_one_cycle", {31'd0, (done & prev_done) | (error & prev_error)}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got done=%0b error=%0b exp none", done, error);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_is_error", {31'd0, error}, {31'd0, mon_e.is_err});
        check("busy_falls_with_result", {31'd0, busy}, 0);
        check("lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        if (mon_e.chk_frame) check("frame_bits", {22'd0, cap_frame}, {22'd0, mon_e.frame});
        if (mon_e.chk_to)    check("timeout_latency", cyc - rts_cyc, TO + 1);
      end
    end
    prev_done   = done;
    prev_error  = error;
    prev_clk_oe = ps2_clk_oe;
    prev_dat_oe = ps2_dat_oe;
  end

  task automatic push_exp(input bit is_err, input bit chk_frame, input bit chk_to,
                          input logic [9:0] frame);
    exp_t e;
    e.is_err = is_err; e.chk_frame = chk_frame; e.chk_to = chk_to; e.frame = frame;
    exp_q.push_back(e);
  endtask

  task automatic do_send(input logic [7:0] d);
    @(negedge clk);
    data = d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 1);
  endtask

  // mode: 0 ACK, 1 NACK, 2 silent device, 3 reset at edge 5
  task automatic run_device(input int mode);
    int n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < int'(INH) + 100) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", {31'd0, ps2_dat_oe & ~ps2_clk_oe}, 1);
    if (mode == 2) begin
      repeat (TO + 20) @(negedge clk);
      return;
    end
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      cap_frame[k-1] = ps2_dat_in;
      if (mode == 3 && k == 5) begin
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_busy",   {31'd0, busy},       0);
        check("reset_done",   {31'd0, done},       0);
        check("reset_error",  {31'd0, error},      0);
        check("reset_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("reset_dat_oe", {31'd0, ps2_dat_oe}, 0);
        rst_n = 1'b1;
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        return;
      end
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (mode == 0) dev_dat = 1'b0;
    repeat (H / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("busy_clear", {31'd0, busy}, 0);
    repeat (10) @(negedge clk);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1};
    vecs[1] = '{PS2_CMD_ENABLE,   1'b0};
    vecs[2] = '{8'h00,            1'b1};

    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy},       0);
    check("rst_done",   {31'd0, done},       0);
    check("rst_error",  {31'd0, error},      0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Normal frames with ACK: frame bits {stop, parity, data}
    foreach (vecs[i]) begin
      push_exp(1'b0, 1'b1, 1'b0, {1'b1, vecs[i].par, vecs[i].d});
      do_send(vecs[i].d);
      run_device(0);
      wait_not_busy();
    end

    // NACK: 0xFF has even popcount so parity bit is 1
    push_exp(1'b1, 1'b1, 1'b0, {1'b1, 1'b1, PS2_CMD_RESET});
    do_send(PS2_CMD_RESET);
    for (int t = 0; t < TRIES; t++) run_device(1);
    wait_not_busy();

    // Silent device: error TO cycles after the RTS cycle ends
    push_exp(1'b1, 1'b0, 1'b1, '0);
    do_send(PS2_CMD_SET_LEDS);
    for (int t = 0; t < TRIES; t++) run_device(2);
    wait_not_busy();

    // Reset in the middle of a frame, then a clean frame
    push_exp(1'b0, 1'b0, 1'b0, '0);
    do_send(PS2_CMD_SET_LEDS);
    run_device(3);
    wait_not_busy();
    push_exp(1'b0, 1'b1, 1'b0, {1'b1, 1'b1, PS2_CMD_SET_LEDS});
    do_send(PS2_CMD_SET_LEDS);
    run_device(0);
    wait_not_busy();

    // Send while busy is ignored
    push_exp(1'b0, 1'b1, 1'b0, {1'b1, 1'b1, PS2_CMD_SET_LEDS});
    do_send(PS2_CMD_SET_LEDS);
    repeat (100) @(negedge clk);
    data = PS2_CMD_RESET;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    data = 8'h00;
    run_device(0);
    wait_not_busy();
    repeat (200) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
